// File: rtl/pwm_duty_scheduler.sv
// Round-robin duty-value scheduler: two requesters feed a small FIFO whose head
// is applied to the PWM datapath only at a period boundary.
module pwm_duty_scheduler #(
    parameter int DW     = 32,
    parameter int DEPTH  = 4,
    parameter int PERIOD = 100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [DW-1:0]              req0_duty,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [DW-1:0]              req1_duty,
    output logic                       req1_ready,
    input  logic                       period_end,
    output logic [DW-1:0]              duty_out,
    output logic                       duty_load,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_rr_ptr;
    logic [DW-1:0]   r_duty_out;
    logic            r_duty_load;

    logic            w_full;
    logic            w_ready0;
    logic            w_ready1;
    logic            w_push;
    logic            w_pop;
    logic            w_load_start;
    logic [DW-1:0]   w_sel_duty;
    logic [DW-1:0]   w_clamped;
    logic [LW-1:0]   w_level_next;

    // Ready depends only on the current level, so a pop frees space one cycle later.
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_ready0   = !rst && !w_full && req0_valid && (!r_rr_ptr || !req1_valid);
    assign w_ready1   = !rst && !w_full && req1_valid && ( r_rr_ptr || !req0_valid);
    assign w_push     = w_ready0 || w_ready1;
    assign w_pop      = (r_state == S_LOAD);
    assign w_sel_duty = w_ready1 ? req1_duty : req0_duty;
    assign w_clamped  = (w_sel_duty > DW'(PERIOD)) ? DW'(PERIOD) : w_sel_duty;

    assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

    always_comb begin
        w_state_next = r_state;
        w_load_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (period_end) begin
                    w_state_next = S_LOAD;
                    w_load_start = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_next = (w_level_next != '0) ? S_ARMED : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_rr_ptr    <= 1'b0;
            r_duty_out  <= '0;
            r_duty_load <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_level     <= w_level_next;
            r_duty_load <= w_load_start;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= w_ready0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Head is captured on the ARMED->LOAD edge so it is visible during LOAD.
            if (w_load_start) begin
                r_duty_out <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_clamped;
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign duty_out   = r_duty_out;
    assign duty_load  = r_duty_load;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench: expected loads are queued at acceptance and checked by a
// separate monitor whenever duty_load pulses.
module tb_pwm_duty_scheduler;

    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid;
    logic [DW-1:0] req0_duty;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_duty;
    logic          req1_ready;
    logic          period_end;
    logic [DW-1:0] duty_out;
    logic          duty_load;
    logic [2:0]    fifo_level;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [DW-1:0] exp_q[$];

    pwm_duty_scheduler #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .PERIOD (PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_duty  (req0_duty),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_duty  (req1_duty),
        .req1_ready (req1_ready),
        .period_end (period_end),
        .duty_out   (duty_out),
        .duty_load  (duty_load),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every load must match the oldest expected value.
    always @(negedge clk) begin
        if (!rst && duty_load === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: got duty_out %0d expected no load", duty_out);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (duty_out !== e) begin
                    errors++;
                    $display("FAIL load_value: got %0d expected %0d", duty_out, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input int r, input logic [DW-1:0] d, input logic [DW-1:0] stored);
        if (r == 0) begin req0_valid = 1'b1; req0_duty = d; end
        else        begin req1_valid = 1'b1; req1_duty = d; end
        @(negedge clk);
        chk("push_ready", (r == 0) ? 32'(req0_ready) : 32'(req1_ready), 1);
        exp_q.push_back(stored);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Pulse period_end in ARMED; load must appear the next cycle, for one cycle only.
    task automatic pulse();
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        @(negedge clk);
        chk("load_pulse", 32'(duty_load), 1);
        step();
        @(negedge clk);
        chk("load_single", 32'(duty_load), 0);
        step();
    endtask

    initial begin
        rst = 1'b1; period_end = 1'b0;
        req0_valid = 1'b1; req0_duty = 32'd9;
        req1_valid = 1'b0; req1_duty = '0;
        idle(2);
        @(negedge clk);
        chk("rst_duty_out", duty_out, 0);
        chk("rst_duty_load", 32'(duty_load), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ready0_forced", 32'(req0_ready), 0);
        step();
        req0_valid = 1'b0;
        rst = 1'b0;

        // Single load, then an empty period_end leaves duty_out alone
        push(0, 32'd30, 32'd30);
        @(negedge clk);
        chk("level_after_push", 32'(fifo_level), 1);
        idle(6);
        pulse();
        @(negedge clk);
        chk("level_after_load", 32'(fifo_level), 0);
        step();
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        @(negedge clk);
        chk("empty_pe_no_load", 32'(duty_load), 0);
        chk("empty_pe_hold", duty_out, 30);
        step();

        // Round-robin until full, then check a pop frees space only a cycle later
        rst = 1'b1; step(); rst = 1'b0;
        req0_valid = 1'b1; req0_duty = 32'd13;
        req1_valid = 1'b1; req1_duty = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
            chk("rr_ready1", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
            exp_q.push_back((i % 2 == 0) ? 32'd13 : 32'd5);
            step();
        end
        @(negedge clk);
        chk("full_level", 32'(fifo_level), 4);
        chk("full_ready0", 32'(req0_ready), 0);
        chk("full_ready1", 32'(req1_ready), 0);
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        @(negedge clk);
        chk("full_load", 32'(duty_load), 1);
        chk("pop_cycle_ready0", 32'(req0_ready), 0);
        chk("pop_cycle_ready1", 32'(req1_ready), 0);
        step();
        @(negedge clk);
        chk("after_pop_level", 32'(fifo_level), 3);
        chk("after_pop_ready0", 32'(req0_ready), 1);
        chk("after_pop_ready1", 32'(req1_ready), 0);
        exp_q.push_back(32'd13);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) pulse();
        @(negedge clk);
        chk("rr_drained", 32'(fifo_level), 0);
        step();

        // Clamp to PERIOD
        push(1, 32'd8432, 32'd100);
        push(1, 32'd20, 32'd20);
        idle(1);
        pulse();
        pulse();

        // Push during LOAD: level unchanged, order preserved
        push(1, 32'd5, 32'd5);
        push(0, 32'd20, 32'd20);
        idle(1);
        @(negedge clk);
        chk("simul_level_before", 32'(fifo_level), 2);
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        req0_valid = 1'b1; req0_duty = 32'd13;
        @(negedge clk);
        chk("simul_ready0", 32'(req0_ready), 1);
        exp_q.push_back(32'd13);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("simul_level_after", 32'(fifo_level), 2);
        step();
        pulse();
        pulse();

        // Reset mid-operation with rr_ptr pointing at requester 1
        push(0, 32'd7, 32'd7);
        push(1, 32'd8, 32'd8);
        push(0, 32'd9, 32'd9);
        idle(1);
        @(negedge clk);
        chk("pre_rst_level", 32'(fifo_level), 3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_duty_out", duty_out, 0);
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        @(negedge clk);
        chk("mid_rst_no_load", 32'(duty_load), 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_rst_rr_ready0", 32'(req0_ready), 1);
        chk("mid_rst_rr_ready1", 32'(req1_ready), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(4);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
